// File: rtl/spi_word_rx_if.sv
// Byte-in / word-out bus for spi_word_rx.
// master: byte source + FIFO reader; slave: the packer.
interface spi_word_rx_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    byte_in;
  logic          byte_rdy;
  logic          rd_en;
  logic          clr_err;
  logic [31:0]   rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic [1:0]    nbytes;
  logic          overflow;
  logic          timeout_err;

  modport master (
    output byte_in, byte_rdy, rd_en, clr_err,
    input  rd_data, empty, full, count,
    input  nbytes, overflow, timeout_err
  );

  modport slave (
    input  byte_in, byte_rdy, rd_en, clr_err,
    output rd_data, empty, full, count,
    output nbytes, overflow, timeout_err
  );
endinterface

// File: rtl/spi_word_rx.sv
// Packs 4 received SPI bytes (LSB first) into 32-bit words and
// buffers them in a FWFT FIFO with sticky overflow/timeout flags.
// Ports: clk, rst (async active-low), bus (spi_word_rx_if.slave):
//   byte_in/byte_rdy in, rd_en pop, clr_err, rd_data head word,
//   empty/full/count FIFO status, nbytes partial-word bytes,
//   overflow, timeout_err sticky flags.
// Optional: SPI_WORD_RX_TIMEOUT_EN discards a partial word after
//   TIMEOUT idle cycles and raises timeout_err.
module spi_word_rx #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  spi_word_rx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [23:0]   asm_q, asm_d;
  logic          rdy_q;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   mem_q [DEPTH];

  logic          byte_fire;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic          is_full;
  logic          is_empty;
  logic          tmo_fire;
  logic [31:0]   word;

  // One byte per rising edge of byte_rdy.
  assign byte_fire = bus.byte_rdy & ~rdy_q;
  assign word      = {bus.byte_in, asm_q};

  assign is_full  = (cnt_q == CW'(DEPTH));
  assign is_empty = (cnt_q == '0);
  assign pop      = bus.rd_en & ~is_empty;
  // A pop frees the slot, so a push while full still lands.
  assign push_ok  = push & (~is_full | pop);

  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    push    = 1'b0;
    if (byte_fire) begin
      unique case (state_q)
        IDLE: begin
          asm_d[7:0] = bus.byte_in;
          state_d    = B1;
        end
        B1: begin
          asm_d[15:8] = bus.byte_in;
          state_d     = B2;
        end
        B2: begin
          asm_d[23:16] = bus.byte_in;
          state_d      = B3;
        end
        B3: begin
          push    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_fire) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + CW'(push_ok) - CW'(pop);
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
    ovf_d = (push & is_full & ~pop) | (ovf_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      asm_q   <= '0;
      rdy_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      rdy_q   <= bus.byte_rdy;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: contents are only visible via count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= word;
  end

`ifdef SPI_WORD_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          terr_q, terr_d;

  // A byte arriving on the expiry cycle wins over the timeout.
  always_comb begin
    tmo_d    = '0;
    tmo_fire = 1'b0;
    if (!byte_fire && state_q != IDLE) begin
      if (tmo_q == TW'(TIMEOUT)) tmo_fire = 1'b1;
      else                       tmo_d    = tmo_q + 1'b1;
    end
    terr_d = tmo_fire | (terr_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      terr_q <= terr_d;
    end
  end

  assign bus.timeout_err = terr_q;
`else
  logic unused_tmo;
  assign unused_tmo      = (TIMEOUT == 0);
  assign tmo_fire        = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.rd_data  = mem_q[rptr_q];
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.count    = cnt_q;
  assign bus.nbytes   = state_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_spi_word_rx.sv
// Self-checking bench for spi_word_rx: vector table + scoreboard
// queue of expected words, plus hand-written corner sequences.
module tb_spi_word_rx;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_word_rx_if #(.DEPTH(DEPTH)) bus ();

  spi_word_rx #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          errs   = 0;
  int          checks = 0;
  logic [31:0] sb[$];
  logic        exp_ovf;
  vec_t        vt[4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.byte_in  = b;
    bus.byte_rdy = 1'b1;
    @(negedge clk);
    bus.byte_rdy = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] b0, b1, b2, b3,
                           input logic [31:0] exp);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    if (sb.size() < DEPTH) sb.push_back(exp);
    else exp_ovf = 1'b1;
  endtask

  task automatic pop_chk(input string nm);
    logic [31:0] e;
    chk({nm, "_nonempty"}, 32'(bus.empty), 0);
    if (sb.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL %s: got %h want none", nm, bus.rd_data);
    end else begin
      e = sb.pop_front();
      chk(nm, bus.rd_data, e);
    end
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.byte_rdy = 1'b0;
    bus.rd_en    = 1'b0;
    bus.clr_err  = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb[4];
    vt[0] = '{8'hde, 8'hc0, 8'had, 8'hde, 32'hdeadc0de};
    vt[1] = '{8'hef, 8'hbe, 8'had, 8'hde, 32'hdeadbeef};
    vt[2] = '{8'hde, 8'hc0, 8'h01, 8'hc0, 32'hc001c0de};
    vt[3] = '{8'hef, 8'hbe, 8'h01, 8'hc0, 32'hc001beef};
    bus.byte_in  = '0;
    bus.byte_rdy = 1'b0;
    bus.rd_en    = 1'b0;
    bus.clr_err  = 1'b0;
    exp_ovf      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_nbytes", 32'(bus.nbytes), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_terr", 32'(bus.timeout_err), 0);
    rst = 1'b1;

    // Pop on empty is ignored.
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("emptypop_count", 32'(bus.count), 0);
    chk("emptypop_empty", 32'(bus.empty), 1);

    // Single word, one cycle latency.
    send_word(vt[0].b0, vt[0].b1, vt[0].b2, vt[0].b3, vt[0].exp);
    chk("w1_empty", 32'(bus.empty), 0);
    chk("w1_count", 32'(bus.count), 1);
    pop_chk("w1_data");
    chk("w1_empty_after", 32'(bus.empty), 1);

    // Four table words without pops, then drain in order.
    for (int i = 0; i < 4; i++)
      send_word(vt[i].b0, vt[i].b1, vt[i].b2, vt[i].b3, vt[i].exp);
    chk("w4_count", 32'(bus.count), 4);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("w4_pop%0d", i));
    chk("w4_empty", 32'(bus.empty), 1);

    // Overflow: nine words into eight slots.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 4; k++) rb[k] = 8'($urandom);
      send_word(rb[0], rb[1], rb[2], rb[3],
                {rb[3], rb[2], rb[1], rb[0]});
    end
    chk("ovf_full", 32'(bus.full), 1);
    chk("ovf_count", 32'(bus.count), 8);
    chk("ovf_flag", 32'(bus.overflow), 32'(exp_ovf));
    for (int i = 0; i < 8; i++) pop_chk($sformatf("ovf_pop%0d", i));
    chk("ovf_empty", 32'(bus.empty), 1);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("ovf_clr", 32'(bus.overflow), 0);

    // Full FIFO: 4th byte together with a pop.
    do_reset();
    for (int i = 0; i < 8; i++)
      send_word(8'(i), 8'h10, 8'h20, 8'h30, {8'h30, 8'h20, 8'h10, 8'(i)});
    send_byte(8'h0d);
    send_byte(8'hf0);
    send_byte(8'had);
    @(negedge clk);
    chk("sim_full", 32'(bus.full), 1);
    chk("sim_head", bus.rd_data, sb.pop_front());
    bus.byte_in  = 8'hba;
    bus.byte_rdy = 1'b1;
    bus.rd_en    = 1'b1;
    sb.push_back(32'hbaadf00d);
    @(negedge clk);
    bus.byte_rdy = 1'b0;
    bus.rd_en    = 1'b0;
    chk("sim_count", 32'(bus.count), 8);
    chk("sim_ovf", 32'(bus.overflow), 0);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("sim_pop%0d", i));

    // Held byte_rdy is one byte; async reset mid-word and mid-FIFO.
    do_reset();
    send_word(8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201);
    @(negedge clk);
    bus.byte_in  = 8'h5a;
    bus.byte_rdy = 1'b1;
    repeat (10) @(negedge clk);
    bus.byte_rdy = 1'b0;
    chk("hold_nbytes", 32'(bus.nbytes), 1);
    send_byte(8'h6b);
    chk("hold_nbytes2", 32'(bus.nbytes), 2);
    #2 rst = 1'b0;
    #1;
    chk("arst_nbytes", 32'(bus.nbytes), 0);
    chk("arst_empty", 32'(bus.empty), 1);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    send_word(8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678);
    chk("arst_count", 32'(bus.count), 1);
    pop_chk("arst_word");
    chk("arst_empty2", 32'(bus.empty), 1);

    // Partial word left idle for 20 cycles.
    do_reset();
    send_byte(8'haa);
    send_byte(8'hbb);
    repeat (20) @(negedge clk);
`ifdef SPI_WORD_RX_TIMEOUT_EN
    chk("tmo_nbytes", 32'(bus.nbytes), 0);
    chk("tmo_err", 32'(bus.timeout_err), 1);
    chk("tmo_empty", 32'(bus.empty), 1);
`else
    chk("hold_idle_nbytes", 32'(bus.nbytes), 2);
    chk("hold_idle_terr", 32'(bus.timeout_err), 0);
    do_reset();
`endif
    send_word(8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211);
    chk("tmo_count", 32'(bus.count), 1);
    pop_chk("tmo_word");
`ifdef SPI_WORD_RX_TIMEOUT_EN
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("tmo_clr", 32'(bus.timeout_err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/spi_word_rx.md
Name: spi_word_rx

Overview:
- Sits directly downstream of spi_slave on the receive side.
- Consumes the received-byte stream (s_rd / s_rdy) and packs every 4 consecutive bytes into one 32-bit word, little-endian: first byte goes to [7:0].
- This matches the MCU word-send routine, which shifts the word right 8 bits after each byte.
- Completed words are buffered in a first-word-fall-through FIFO for a consumer (bench checker or MMIO reader), with full/empty/overflow status.

Parameters:
- DEPTH, 8, FIFO depth in words; must be a power of 2, ≥ 2.
- TIMEOUT, 255, inter-byte timeout in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- byte_in  in  8  received byte; connects to spi_slave rd.
- byte_rdy  in  1  spi_slave rdy; byte_in is valid while high.
- rd_en  in  1  pop head word.
- clr_err  in  1  clears the sticky error flags.
- rd_data  out  32  head word; valid while empty=0.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  $clog2(DEPTH)+1  words stored.
- nbytes  out  2  bytes held in the partial word.
- overflow  out  1  sticky: a completed word was dropped.
- timeout_err  out  1  sticky: a partial word was discarded on timeout.

Behaviour:
- Reset (rst=0, async):
  - Pointers, count, nbytes, assembly register, overflow, timeout_err and timeout counter all go to 0.
  - empty=1, full=0. rd_data is undefined (don't care) while empty.
  - Reset mid-word discards the partial word; reset mid-FIFO discards all stored words.
- Byte capture:
  - A byte is accepted on the first clk edge where byte_rdy=1 and byte_rdy was 0 on the previous edge (edge-detect register, reset value 0).
  - A level held high for many cycles is one byte.
  - Back-to-back bytes need byte_rdy low for ≥1 cycle in between.
- Assembly:
  - Accepted byte k (k = nbytes) is written to assembly[8k+7:8k]; nbytes increments.
  - On the 4th byte (nbytes=3), the full word {byte_in, assembly[23:0]} is pushed in the same cycle. nbytes wraps to 0. The assembly register need not be cleared.
  - Word latency: the word is visible on rd_data with empty=0 one cycle after the 4th byte edge, provided the FIFO was empty.
- FIFO:
  - Write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy.
  - full = (count==DEPTH); empty = (count==0).
  - Read: rd_en=1 with empty=0 advances the read pointer and decrements count. rd_en while empty is ignored, with no state change.
  - Push while full and no pop in the same cycle: the word is dropped, overflow is set to 1, and FIFO contents are unchanged.
  - Push and pop in the same cycle: both take effect and count is unchanged. This applies when full as well: the push is accepted and overflow is not set.
  - Push with empty=1 and rd_en=1 in the same cycle: rd_en is ignored and the push is accepted.
- Errors:
  - clr_err=1 clears overflow and timeout_err on the next edge.
  - If an error event occurs in the same cycle as clr_err, the flag is set (set wins).
- State summary: the assembler is a 4-state cycle IDLE(0) → B1 → B2 → B3 → IDLE, encoded by nbytes. Each transition happens on a byte edge.

Optional Feature:
- Macro: SPI_WORD_RX_TIMEOUT_EN.
- Defined:
  - A cycle counter of width $clog2(TIMEOUT+1) resets to 0 on every accepted byte. It increments while nbytes≠0 and holds at 0 while nbytes=0.
  - When it reaches TIMEOUT with nbytes≠0: nbytes←0 (partial word discarded), timeout_err←1, counter←0.
  - If a byte edge arrives in the same cycle the counter reaches TIMEOUT, the byte wins: it is accepted and no timeout fires.
- Undefined: no counter is built, timeout_err is tied to 0, and partial words are held indefinitely.

Test Plan:
- After reset, send bytes de,c0,ad,de → one cycle later empty=0, count=1, rd_data=32'hdeadc0de; pop → empty=1.
- Send 4 words (deadc0de, deadbeef, c001c0de, c001beef) as 16 LSB-first bytes with no pops → count=4; popping 4 times returns them in order; then empty=1.
- DEPTH=8: push 9 words with no pops → full=1, count=8, overflow=1; 8 pops return words 1–8; clr_err → overflow=0.
- FIFO full, 4th byte arrives in the same cycle as rd_en → count stays 8, overflow=0, and the last pop returns the new word.
- Hold byte_rdy high for 10 cycles → nbytes=1, not 10. Assert rst=0 after 2 bytes → nbytes=0, empty=1; then 4 new bytes produce exactly one correct word.
- With SPI_WORD_RX_TIMEOUT_EN, TIMEOUT=16: send 2 bytes, then wait 20 cycles → nbytes=0, timeout_err=1; then bytes 11,22,33,44 → rd_data=32'h44332211.
